jpeg_idct_blk_ctrl: RTL and testbench
=====================================

JPEG_IDCT_BLK_CTRL -- requirements
Module: jpeg_idct_blk_ctrl

Interface
REQ-001 The block SHALL take parameter BLK_DEPTH, default 2: the maximum number of 8x8 blocks (64 entries each) the attached coefficient FIFO can hold.
REQ-002 The block SHALL take parameter BLK_W, default 2: the width of the block counters, sized to hold 0..BLK_DEPTH.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: synchronous abort of all buffered blocks.
REQ-006 The block SHALL have port inport_valid_i, input, 1 bit: the upstream producer offers one coefficient.
REQ-007 The block SHALL have port inport_accept_o, output, 1 bit: the coefficient is taken this cycle.
REQ-008 The block SHALL have port fifo_push_o, output, 1 bit: write strobe to the FIFO.
REQ-009 The block SHALL have port fifo_accept_i, input, 1 bit: the FIFO has space.
REQ-010 The block SHALL have port fifo_valid_i, input, 1 bit: the FIFO has data.
REQ-011 The block SHALL have port fifo_pop_o, output, 1 bit: read strobe to the FIFO.
REQ-012 The block SHALL have port fifo_flush_o, output, 1 bit: flush to the FIFO.
REQ-013 The block SHALL have port outport_valid_o, output, 1 bit: the downstream IDCT receives one coefficient.
REQ-014 The block SHALL have port outport_accept_i, input, 1 bit: downstream takes the coefficient.
REQ-015 The block SHALL have port outport_idx_o, output, 6 bits: position 0..63 of the current coefficient within its block.
REQ-016 The block SHALL have port outport_last_o, output, 1 bit: the current coefficient is index 63.
REQ-017 The block SHALL have port blocks_o, output, BLK_W bits: the number of complete blocks resident in the FIFO.
REQ-018 The block SHALL have port idle_o, output, 1 bit: no block is in flight.

Function
REQ-019 The block SHALL define wr_cnt (6b), rd_cnt (6b), inflight (BLK_W), full_blks (BLK_W) and rd_state {RD_IDLE, RD_ACTIVE}.
REQ-020 The block SHALL drive inport_accept_o = fifo_accept_i & (wr_cnt!=0 | inflight<BLK_DEPTH), and fifo_push_o = inport_valid_i & inport_accept_o, both combinationally.
REQ-021 A push with wr_cnt==0 SHALL open a block: inflight+1.
REQ-022 Every push SHALL increment wr_cnt.
REQ-023 A push with wr_cnt==63 SHALL close the block: wr_cnt wraps to 0 and full_blks+1.
REQ-024 In RD_IDLE, the block SHALL enter RD_ACTIVE next cycle when full_blks!=0, with rd_cnt=0.
REQ-025 The block SHALL drive outport_valid_o = (rd_state==RD_ACTIVE) & fifo_valid_i, and fifo_pop_o = outport_valid_o & outport_accept_i.
REQ-026 outport_idx_o SHALL equal rd_cnt, and outport_last_o SHALL equal (rd_cnt==63) & outport_valid_o.
REQ-027 Each pop SHALL increment rd_cnt.
REQ-028 A pop at rd_cnt==63 SHALL wrap rd_cnt to 0, decrement full_blks and inflight, and return to RD_IDLE, or stay in RD_ACTIVE if full_blks after update is non-zero.
REQ-029 When a block close and a block read completion occur in the same cycle, full_blks SHALL be unchanged.
REQ-030 When a block open and a block read completion occur in the same cycle, inflight SHALL be unchanged.
REQ-031 A partial block (wr_cnt!=0) SHALL never be presented downstream: read starts only from full_blks.
REQ-032 fifo_flush_o SHALL equal flush_i | rst_i, combinationally.
REQ-033 flush_i SHALL clear wr_cnt, rd_cnt, inflight and full_blks and force RD_IDLE next cycle, mid-block included.
REQ-034 During a flush_i cycle, inport_accept_o, fifo_push_o, fifo_pop_o and outport_valid_o SHALL be forced to 0.
REQ-035 blocks_o SHALL equal full_blks.
REQ-036 idle_o SHALL equal (inflight==0) & (rd_state==RD_IDLE).
REQ-037 A fifo_valid_i low while in RD_ACTIVE SHALL stall with no state change; this is a FIFO underflow and is not expected in normal operation.

Reset
REQ-038 While rst_i is high, the block SHALL clear all counters, set RD_IDLE, hold inport_accept_o=0, fifo_push_o=0, fifo_pop_o=0 and outport_valid_o=0, and drive fifo_flush_o=1, outport_idx_o=0, outport_last_o=0, blocks_o=0 and idle_o=1.
REQ-039 The first accept SHALL be possible in the cycle after rst_i falls.
REQ-040 Reset SHALL take priority over flush_i.

Verification
REQ-041 Scenario: push 64 coefficients back-to-back with outport_accept_i=1 -> blocks_o=1 one cycle after push 64; outport_valid_o two cycles after push 64; idx 0..63 with last at 63; idle_o=1 after the final pop.
REQ-042 Scenario: BLK_DEPTH=2, downstream stalled, 200 coefficients offered -> 128 accepted; inport_accept_o=0 at coefficient 129; blocks_o=2.
REQ-043 Scenario: block 2 closes in the same cycle block 1's idx 63 pops -> blocks_o stays 1; the read continues without returning to RD_IDLE.
REQ-044 Scenario: flush_i after 30 coefficients of block 1 -> fifo_flush_o=1 that cycle; next cycle blocks_o=0, idle_o=1; the following block starts at idx 0.
REQ-045 Scenario: rst_i asserted mid-read at idx 17 -> next cycle outport_valid_o=0, outport_idx_o=0, blocks_o=0.
REQ-046 Scenario: outport_accept_i toggling 1/0 during a read -> idx advances only on accepted cycles; exactly 64 pops per block.

Source files
------------

// File: rtl/jpeg_idct_blk_ctrl.sv
// Block-level flow control between a coefficient producer, a block FIFO and the IDCT.
// Only whole 8x8 blocks (64 coefficients) are released downstream. Counters are bounded by BLK_DEPTH.
module jpeg_idct_blk_ctrl #(
    parameter int BLK_DEPTH = 2,
    parameter int BLK_W     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             inport_valid_i,
    output logic             inport_accept_o,
    output logic             fifo_push_o,
    input  logic             fifo_accept_i,
    input  logic             fifo_valid_i,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    output logic             outport_valid_o,
    input  logic             outport_accept_i,
    output logic [5:0]       outport_idx_o,
    output logic             outport_last_o,
    output logic [BLK_W-1:0] blocks_o,
    output logic             idle_o
);

    typedef enum logic {
        RD_IDLE,
        RD_ACTIVE
    } rd_state_t;

    rd_state_t        rd_state, rd_state_nxt;
    logic [5:0]       wr_cnt, wr_cnt_nxt;
    logic [5:0]       rd_cnt, rd_cnt_nxt;
    logic [BLK_W-1:0] inflight, inflight_nxt;
    logic [BLK_W-1:0] full_blks, full_blks_nxt;

    logic             abort;
    logic             blk_open;
    logic             blk_close;
    logic             rd_done;

    assign abort = flush_i | rst_i;

    // A new block may only be opened while the FIFO has room for a whole block.
    assign inport_accept_o = fifo_accept_i & ~abort
                           & ((wr_cnt != 6'd0) | (inflight < BLK_W'(BLK_DEPTH)));
    assign fifo_push_o     = inport_valid_i & inport_accept_o;

    assign outport_valid_o = (rd_state == RD_ACTIVE) & fifo_valid_i & ~abort;
    assign fifo_pop_o      = outport_valid_o & outport_accept_i;
    assign outport_idx_o   = rst_i ? 6'd0 : rd_cnt;
    assign outport_last_o  = (rd_cnt == 6'd63) & outport_valid_o;
    assign fifo_flush_o    = abort;
    assign blocks_o        = rst_i ? '0 : full_blks;
    assign idle_o          = rst_i | ((inflight == '0) & (rd_state == RD_IDLE));

    assign blk_open  = fifo_push_o & (wr_cnt == 6'd0);
    assign blk_close = fifo_push_o & (wr_cnt == 6'd63);
    assign rd_done   = fifo_pop_o & (rd_cnt == 6'd63);

    always_comb begin
        rd_state_nxt  = rd_state;
        wr_cnt_nxt    = wr_cnt;
        rd_cnt_nxt    = rd_cnt;
        inflight_nxt  = inflight;
        full_blks_nxt = full_blks;

        if (flush_i) begin
            rd_state_nxt  = RD_IDLE;
            wr_cnt_nxt    = 6'd0;
            rd_cnt_nxt    = 6'd0;
            inflight_nxt  = '0;
            full_blks_nxt = '0;
        end else begin
            // The 6-bit counters wrap from 63 to 0 on their own at a block boundary.
            if (fifo_push_o)
                wr_cnt_nxt = wr_cnt + 6'd1;
            if (fifo_pop_o)
                rd_cnt_nxt = rd_cnt + 6'd1;
            full_blks_nxt = full_blks + BLK_W'(blk_close) - BLK_W'(rd_done);
            inflight_nxt  = inflight + BLK_W'(blk_open) - BLK_W'(rd_done);

            case (rd_state)
                RD_IDLE: begin
                    if (full_blks != '0) begin
                        rd_state_nxt = RD_ACTIVE;
                        rd_cnt_nxt   = 6'd0;
                    end
                end
                RD_ACTIVE: begin
                    if (rd_done && (full_blks_nxt == '0))
                        rd_state_nxt = RD_IDLE;
                end
                default: rd_state_nxt = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state  <= RD_IDLE;
            wr_cnt    <= 6'd0;
            rd_cnt    <= 6'd0;
            inflight  <= '0;
            full_blks <= '0;
        end else begin
            rd_state  <= rd_state_nxt;
            wr_cnt    <= wr_cnt_nxt;
            rd_cnt    <= rd_cnt_nxt;
            inflight  <= inflight_nxt;
            full_blks <= full_blks_nxt;
        end
    end

endmodule

// File: tb/tb_jpeg_idct_blk_ctrl.sv
// Scoreboard bench for jpeg_idct_blk_ctrl: completed blocks queue their expected idx sequence,
// a negedge monitor checks every pop against it; directed checks cover timing and flush/reset.
module tb_jpeg_idct_blk_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_accept;
    logic       fifo_push;
    logic       fifo_acc;
    logic       fifo_valid;
    logic       fifo_pop;
    logic       fifo_flush;
    logic       out_valid;
    logic       out_acc;
    logic [5:0] out_idx;
    logic       out_last;
    logic [1:0] blocks;
    logic       idle;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int wr_model   = 0;
    int push_total = 0;
    int pop_total  = 0;
    int fifo_cnt   = 0;

    jpeg_idct_blk_ctrl #(.BLK_DEPTH(2), .BLK_W(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .inport_valid_i  (in_valid),
        .inport_accept_o (in_accept),
        .fifo_push_o     (fifo_push),
        .fifo_accept_i   (fifo_acc),
        .fifo_valid_i    (fifo_valid),
        .fifo_pop_o      (fifo_pop),
        .fifo_flush_o    (fifo_flush),
        .outport_valid_o (out_valid),
        .outport_accept_i(out_acc),
        .outport_idx_o   (out_idx),
        .outport_last_o  (out_last),
        .blocks_o        (blocks),
        .idle_o          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy model of the attached coefficient FIFO.
    always @(posedge clk) begin
        if (fifo_flush)
            fifo_cnt <= 0;
        else
            fifo_cnt <= fifo_cnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
    assign fifo_valid = (fifo_cnt != 0);

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (fifo_flush) begin
            chk("no_pop_in_flush", int'(fifo_pop), 0);
            chk("no_push_in_flush", int'(fifo_push), 0);
            wr_model = 0;
            exp_q.delete();
        end else begin
            if (fifo_push) begin
                push_total++;
                wr_model++;
                if (wr_model == 64) begin
                    wr_model = 0;
                    for (int k = 0; k < 64; k++) exp_q.push_back(k);
                end
            end
            if (fifo_pop) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("pop_idx", int'(out_idx), e);
                    chk("pop_last", int'(out_last), (e == 63) ? 1 : 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!(idle && exp_q.size() == 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_idle"}, int'(idle), 1);
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_acc = 1'b0; fifo_acc = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_fifo_flush", int'(fifo_flush), 1);
        chk("rst_accept", int'(in_accept), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_blocks", int'(blocks), 0);
        chk("rst_idle", int'(idle), 1);

        // Single block, back to back, downstream always ready.
        cyc();
        rst = 1'b0; in_valid = 1'b1; out_acc = 1'b1;
        @(negedge clk);
        chk("first_accept", int'(in_accept), 1);
        chk("first_push", int'(fifo_push), 1);
        chk("flush_released", int'(fifo_flush), 0);
        repeat (63) cyc();
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("s1_blocks_after_close", int'(blocks), 1);
        chk("s1_valid_not_yet", int'(out_valid), 0);
        cyc();
        @(negedge clk);
        chk("s1_valid_two_after", int'(out_valid), 1);
        chk("s1_first_idx", int'(out_idx), 0);
        wait_drain("s1");
        chk("s1_blocks_end", int'(blocks), 0);

        // Downstream stalled: only two whole blocks fit.
        cyc();
        out_acc = 1'b0; in_valid = 1'b1;
        p0 = push_total;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 127) chk("s2_accept_128", int'(in_accept), 1);
            if (i == 128) chk("s2_accept_129", int'(in_accept), 0);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("s2_accepted", push_total - p0, 128);
        chk("s2_blocks", int'(blocks), 2);
        cyc();
        out_acc = 1'b1;
        wait_drain("s2");

        // Block 2 closes in the same cycle block 1 pops idx 63.
        cyc();
        in_valid = 1'b1; out_acc = 1'b1;
        repeat (64) cyc();
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        repeat (64) cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("s3_blocks", int'(blocks), 1);
        chk("s3_still_active", int'(out_valid), 1);
        chk("s3_idx_restart", int'(out_idx), 0);
        chk("s3_not_idle", int'(idle), 0);
        wait_drain("s3");

        // Flush part-way through block 1.
        cyc();
        in_valid = 1'b1;
        repeat (30) cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("s4_fifo_flush", int'(fifo_flush), 1);
        chk("s4_accept_forced", int'(in_accept), 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("s4_blocks", int'(blocks), 0);
        chk("s4_idle", int'(idle), 1);
        cyc();
        in_valid = 1'b1;
        repeat (64) cyc();
        in_valid = 1'b0;
        wait_drain("s4");

        // Reset in the middle of a read.
        cyc();
        in_valid = 1'b1; out_acc = 1'b1;
        repeat (64) cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid && out_idx == 6'd17) break;
            cyc();
        end
        chk("s5_reach_17", int'(out_idx), 17);
        rst = 1'b1;
        @(negedge clk);
        chk("s5_valid_in_rst", int'(out_valid), 0);
        cyc();
        @(negedge clk);
        chk("s5_valid_next", int'(out_valid), 0);
        chk("s5_idx_next", int'(out_idx), 0);
        chk("s5_blocks_next", int'(blocks), 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("s5_idle_after", int'(idle), 1);
        chk("s5_accept_after", int'(in_accept), 1);

        // Downstream accept toggling.
        cyc();
        out_acc = 1'b0; in_valid = 1'b1;
        repeat (64) cyc();
        in_valid = 1'b0;
        p0 = pop_total;
        for (int k = 0; k < 400; k++) begin
            if (idle && exp_q.size() == 0) break;
            cyc();
            out_acc = ~out_acc;
        end
        chk("s6_pops", pop_total - p0, 64);
        out_acc = 1'b1;
        wait_drain("s6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
